// File: rtl/clk_div_frac_pkg.sv
// Shared types and constants for the multi-channel fractional clock divider.
package clk_div_frac_pkg;

    // Width of the channel index carried on the write port
    localparam int unsigned CChIdxW  = 4;

    // Default divider-word field widths
    localparam int unsigned CDefIntW = 8;
    localparam int unsigned CDefFraW = 4;

    // Divider word as written by software: integer half-period above fraction
    typedef struct packed {
        logic [CDefIntW-1:0] Int;
        logic [CDefFraW-1:0] Fra;
    } divWord_t;

endpackage

// File: rtl/clk_div_frac_ch.sv
// One divider channel: active/shadow divider word, half-period counter and
// output clock. Fractional accumulation is built only when
// CLK_DIV_FRAC_MULTI_FRAC_EN is defined; otherwise Fra is stored but ignored.
module clk_div_frac_ch
    import clk_div_frac_pkg::*;
#(
    parameter int unsigned CIntW = CDefIntW,
    parameter int unsigned CFraW = CDefFraW
) (
    input  logic             AClkH,
    input  logic             AResetH,
    input  logic             AClkHEn,
    input  logic             AChEn,
    input  logic             ASyncStart,
    input  logic             AWrHit,
    input  logic [CIntW-1:0] AWrInt,
    input  logic [CFraW-1:0] AWrFra,
    output logic             AClkOut,
    output logic             ATick
);

    logic [CIntW-1:0] intAct, intActNxt, intShd, intShdNxt;
    logic [CFraW-1:0] fraAct, fraActNxt, fraShd, fraShdNxt;
    logic             pend, pendNxt;
    logic [CIntW-1:0] fCnt, cntNxt;
    logic             fClkOut, clkNxt;
    logic             accClr, accStep;
    logic             carry;

`ifdef CLK_DIV_FRAC_MULTI_FRAC_EN
    logic [CFraW-1:0] fAcc, accNxt;
    logic [CFraW:0]   accSum;

    assign accSum = {1'b0, fAcc} + {1'b0, fraAct};
    assign carry  = accSum[CFraW];

    // Accumulator next value: cleared on restart/new word, stepped on a reload
    always_comb begin
        accNxt = fAcc;
        if (accClr) begin
            accNxt = '0;
        end else if (accStep) begin
            accNxt = accSum[CFraW-1:0];
        end
    end

    // Accumulator register
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            fAcc <= '0;
        end else if (AClkHEn) begin
            fAcc <= accNxt;
        end
    end
`else
    logic unusedFra;

    assign carry = 1'b0;
    // Fra is held in the active word but has no consumer in this build
    assign unusedFra = ^{fraAct, accClr, accStep};
`endif

    // Next-state: sync restart, idle/disabled hold, count-down, reload/apply
    always_comb begin
        intActNxt = intAct;
        fraActNxt = fraAct;
        intShdNxt = intShd;
        fraShdNxt = fraShd;
        pendNxt   = pend;
        cntNxt    = fCnt;
        clkNxt    = fClkOut;
        accClr    = 1'b0;
        accStep   = 1'b0;
        if (ASyncStart) begin
            cntNxt  = '0;
            clkNxt  = 1'b0;
            accClr  = 1'b1;
            pendNxt = 1'b0;
            if (AWrHit) begin
                intActNxt = AWrInt;
                fraActNxt = AWrFra;
                intShdNxt = AWrInt;
                fraShdNxt = AWrFra;
            end else if (pend) begin
                intActNxt = intShd;
                fraActNxt = fraShd;
            end
        end else begin
            if (!AChEn || (intAct == '0)) begin
                cntNxt = '0;
                clkNxt = 1'b0;
                accClr = 1'b1;
                if (pend) begin
                    intActNxt = intShd;
                    fraActNxt = fraShd;
                    pendNxt   = 1'b0;
                end
            end else if (fCnt != '0) begin
                cntNxt = fCnt - CIntW'(1);
            end else begin
                clkNxt = ~fClkOut;
                if (fClkOut && pend) begin
                    intActNxt = intShd;
                    fraActNxt = fraShd;
                    pendNxt   = 1'b0;
                    accClr    = 1'b1;
                    cntNxt    = (intShd == '0) ? '0 : intShd - CIntW'(1);
                end else begin
                    accStep = 1'b1;
                    cntNxt  = intAct - CIntW'(1) + CIntW'(carry);
                end
            end
            // A new write lands in the shadow after any apply this cycle
            if (AWrHit) begin
                intShdNxt = AWrInt;
                fraShdNxt = AWrFra;
                pendNxt   = 1'b1;
            end
        end
    end

    // Channel state registers, frozen while the clock enable is low
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            intAct  <= '0;
            fraAct  <= '0;
            intShd  <= '0;
            fraShd  <= '0;
            pend    <= 1'b0;
            fCnt    <= '0;
            fClkOut <= 1'b0;
        end else if (AClkHEn) begin
            intAct  <= intActNxt;
            fraAct  <= fraActNxt;
            intShd  <= intShdNxt;
            fraShd  <= fraShdNxt;
            pend    <= pendNxt;
            fCnt    <= cntNxt;
            fClkOut <= clkNxt;
        end
    end

    assign AClkOut = fClkOut;
    // End-of-period marker: last high cycle of a running channel
    assign ATick   = (fCnt == '0) & fClkOut & AChEn & (intAct != '0) & AClkHEn & ~AResetH;

endmodule

// File: rtl/clk_div_frac_multi.sv
// Multi-channel fractional clock divider top: write decode, ack/err pulses and
// one clk_div_frac_ch per channel. Fractional mode: CLK_DIV_FRAC_MULTI_FRAC_EN.
module clk_div_frac_multi
    import clk_div_frac_pkg::*;
#(
    parameter int unsigned CChCnt = 4,
    parameter int unsigned CIntW  = CDefIntW,
    parameter int unsigned CFraW  = CDefFraW
) (
    input  logic                   AClkH,
    input  logic                   AResetH,
    input  logic                   AClkHEn,
    input  logic                   AWrEn,
    input  logic [CChIdxW-1:0]     AWrCh,
    input  logic [CIntW+CFraW-1:0] AWrData,
    output logic                   AWrAck,
    output logic                   AWrErr,
    input  logic [CChCnt-1:0]      AChEn,
    input  logic                   ASyncStart,
    output logic [CChCnt-1:0]      AClkOut,
    output logic [CChCnt-1:0]      ATick
);

    localparam int unsigned CCmpW = CChIdxW + 1;

    logic wrReq, wrInRange, wrOk, wrBad, syncGo;

    // Write decode: writes and sync pulses only count on enabled cycles
    assign wrReq     = AClkHEn & AWrEn;
    assign wrInRange = ({1'b0, AWrCh} < CCmpW'(CChCnt));
    assign wrOk      = wrReq & wrInRange;
    assign wrBad     = wrReq & ~wrInRange;
    assign syncGo    = AClkHEn & ASyncStart;

    // Single-cycle ack/err pulses for the previous cycle's write
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            AWrAck <= 1'b0;
            AWrErr <= 1'b0;
        end else begin
            AWrAck <= wrOk;
            AWrErr <= wrBad;
        end
    end

    for (genvar i = 0; i < int'(CChCnt); i++) begin : gCh
        logic wrHit;

        assign wrHit = wrOk & (AWrCh == CChIdxW'(i));

        clk_div_frac_ch #(
            .CIntW (CIntW),
            .CFraW (CFraW)
        ) uCh (
            .AClkH      (AClkH),
            .AResetH    (AResetH),
            .AClkHEn    (AClkHEn),
            .AChEn      (AChEn[i]),
            .ASyncStart (syncGo),
            .AWrHit     (wrHit),
            .AWrInt     (AWrData[CIntW+CFraW-1:CFraW]),
            .AWrFra     (AWrData[CFraW-1:0]),
            .AClkOut    (AClkOut[i]),
            .ATick      (ATick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_frac_multi.sv
// Directed bench for clk_div_frac_multi (4 channels, 8-bit Int, 4-bit Fra).
module tb_clk_div_frac_multi;
    import clk_div_frac_pkg::*;

`ifdef CLK_DIV_FRAC_MULTI_FRAC_EN
    localparam int CExpLoB = 3;
`else
    localparam int CExpLoB = 2;
`endif

    logic        AClkH;
    logic        AResetH;
    logic        AClkHEn;
    logic        AWrEn;
    logic [3:0]  AWrCh;
    logic [11:0] AWrData;
    logic        AWrAck;
    logic        AWrErr;
    logic [3:0]  AChEn;
    logic        ASyncStart;
    logic [3:0]  AClkOut;
    logic [3:0]  ATick;

    int total = 0;
    int bad   = 0;

    clk_div_frac_multi #(
        .CChCnt (4),
        .CIntW  (8),
        .CFraW  (4)
    ) dut (
        .AClkH      (AClkH),
        .AResetH    (AResetH),
        .AClkHEn    (AClkHEn),
        .AWrEn      (AWrEn),
        .AWrCh      (AWrCh),
        .AWrData    (AWrData),
        .AWrAck     (AWrAck),
        .AWrErr     (AWrErr),
        .AChEn      (AChEn),
        .ASyncStart (ASyncStart),
        .AClkOut    (AClkOut),
        .ATick      (ATick)
    );

    initial AClkH = 1'b0;
    always #5 AClkH = ~AClkH;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge AClkH);
    endtask

    function automatic logic [11:0] mkw(input int iv, input int fv);
        divWord_t w;
        w.Int = 8'(iv);
        w.Fra = 4'(fv);
        return w;
    endfunction

    task automatic wr(input int ch, input int iv, input int fv);
        AWrEn   = 1'b1;
        AWrCh   = 4'(ch);
        AWrData = mkw(iv, fv);
        tick();
        AWrEn   = 1'b0;
    endtask

    task automatic waitLvl(input int ch, input logic lvl, input string tag);
        int n;
        n = 0;
        while (AClkOut[ch] !== lvl && n < 200) begin
            n++;
            tick();
        end
        chk(tag, 32'(AClkOut[ch]), 32'(lvl));
    endtask

    task automatic cntRun(input int ch, output int n);
        logic lvl;
        lvl = AClkOut[ch];
        n = 0;
        while (AClkOut[ch] === lvl && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic measPer(input int ch, output int hi, output int lo, output int tk, output int tp);
        hi = 0; lo = 0; tk = 0; tp = 0;
        while (AClkOut[ch] === 1'b1 && hi < 200) begin
            hi++;
            if (ATick[ch]) begin tk++; tp = hi; end
            tick();
        end
        while (AClkOut[ch] === 1'b0 && lo < 200) begin
            lo++;
            if (ATick[ch]) tk++;
            tick();
        end
    endtask

    initial begin
        int hi, lo, tk, tp, n;
        logic [31:0] h0, h1, e0, e1;

        AResetH = 1'b1; AClkHEn = 1'b1; AWrEn = 1'b0; AWrCh = '0;
        AWrData = '0; AChEn = '0; ASyncStart = 1'b0;
        tick(); tick();
        chk("rst_clkout", 32'(AClkOut), 0);
        chk("rst_tick",   32'(ATick), 0);
        chk("rst_ack",    32'(AWrAck), 0);
        chk("rst_err",    32'(AWrErr), 0);
        AResetH = 1'b0;
        tick();

        // Ch0 Int=3: 3 high / 3 low, one tick in the last high cycle
        wr(0, 3, 0);
        chk("a_ack", 32'(AWrAck), 1);
        chk("a_err", 32'(AWrErr), 0);
        AChEn = 4'b0001;
        waitLvl(0, 1'b1, "a_rise");
        for (int p = 0; p < 2; p++) begin
            measPer(0, hi, lo, tk, tp);
            chk("a_hi", 32'(hi), 3);
            chk("a_lo", 32'(lo), 3);
            chk("a_tick_cnt", 32'(tk), 1);
            chk("a_tick_pos", 32'(tp), 3);
        end

        // Ch1 Int=2 Fra=8: halves 2,3 with fraction, 2,2 without
        wr(1, 2, 8);
        AChEn = 4'b0011;
        waitLvl(1, 1'b1, "b_rise");
        for (int p = 0; p < 2; p++) begin
            measPer(1, hi, lo, tk, tp);
            chk("b_hi", 32'(hi), 2);
            chk("b_lo", 32'(lo), 32'(CExpLoB));
            chk("b_tick_cnt", 32'(tk), 1);
        end

        // Ch0 Int=4 then Int=2 written mid-high: old period ends, then 2/2
        AChEn = 4'b0010;
        wr(0, 4, 0);
        tick();
        AChEn = 4'b0011;
        waitLvl(0, 1'b1, "c_rise");
        waitLvl(0, 1'b0, "c_fall");
        cntRun(0, n);
        chk("c_lo_old", 32'(n), 4);
        tick();
        wr(0, 2, 0);
        chk("c_ack", 32'(AWrAck), 1);
        tick();
        chk("c_ack_once", 32'(AWrAck), 0);
        cntRun(0, n);
        chk("c_hi_old_rest", 32'(n), 1);
        cntRun(0, n);
        chk("c_lo_new", 32'(n), 2);
        cntRun(0, n);
        chk("c_hi_new", 32'(n), 2);

        // Ch2 Int=0 written while high: falls at boundary and stays low
        wr(2, 3, 0);
        AChEn = 4'b0111;
        waitLvl(2, 1'b1, "d_rise");
        wr(2, 0, 0);
        chk("d_ack", 32'(AWrAck), 1);
        waitLvl(2, 1'b0, "d_fall");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (AClkOut[2] !== 1'b0 || ATick[2] !== 1'b0) n++;
            tick();
        end
        chk("d_stay_low", 32'(n), 0);

        // Out-of-range channel: error pulse, no state change anywhere
        wr(5, 7, 0);
        chk("d_err", 32'(AWrErr), 1);
        chk("d_no_ack", 32'(AWrAck), 0);
        tick();
        chk("d_err_once", 32'(AWrErr), 0);
        waitLvl(0, 1'b0, "d_c0_fall");
        waitLvl(0, 1'b1, "d_c0_rise");
        measPer(0, hi, lo, tk, tp);
        chk("d_c0_hi", 32'(hi), 2);
        chk("d_c0_lo", 32'(lo), 2);
        waitLvl(1, 1'b0, "d_c1_fall");
        waitLvl(1, 1'b1, "d_c1_rise");
        measPer(1, hi, lo, tk, tp);
        chk("d_c1_hi", 32'(hi), 2);
        chk("d_c1_lo", 32'(lo), 32'(CExpLoB));

        // Sync start with ch0 Int=3 pending and ch1 Int=6 written same cycle
        wr(0, 3, 0);
        AWrEn = 1'b1; AWrCh = 4'd1; AWrData = mkw(6, 0); ASyncStart = 1'b1;
        tick();
        AWrEn = 1'b0; ASyncStart = 1'b0;
        chk("e_sync_clr", 32'(AClkOut[1:0]), 0);
        chk("e_sync_ack", 32'(AWrAck), 1);
        tick();
        chk("e_same_rise", 32'(AClkOut[1:0]), 3);
        h0 = '0; h1 = '0; e0 = '0; e1 = '0;
        for (int t = 1; t <= 24; t++) begin
            h0[t] = ATick[0];
            h1[t] = ATick[1];
            e0[t] = ((t % 6) == 3);
            e1[t] = ((t % 12) == 6);
            tick();
        end
        chk("e_tick0", h0, e0);
        chk("e_tick1", h1, e1);
        chk("e_tick1_lock", h1 & ~(h0 << 3), 0);

        // Clock enable low for 5 cycles in the last high cycle of ch0
        waitLvl(0, 1'b0, "f_fall");
        waitLvl(0, 1'b1, "f_rise");
        tick(); tick();
        chk("f_tick_before", 32'(ATick[0]), 1);
        AClkHEn = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (AClkOut[0] !== 1'b1 || ATick !== 4'b0000) n++;
        end
        chk("f_frozen", 32'(n), 0);
        AClkHEn = 1'b1;
        tick();
        chk("f_fall_after_stretch", 32'(AClkOut[0]), 0);
        cntRun(0, n);
        chk("f_lo", 32'(n), 3);

        // Reset mid-period clears everything including the divider words
        waitLvl(0, 1'b1, "r_rise");
        AResetH = 1'b1;
        tick();
        chk("r_clkout", 32'(AClkOut), 0);
        chk("r_tick", 32'(ATick), 0);
        chk("r_ack", 32'(AWrAck), 0);
        AResetH = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("r_int_cleared", 32'(AClkOut), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
